// File: rtl/run_ctrl_if.sv
// Host/core-facing signal bundle of the run sequencer.
// master = host and core side, slave = run_ctrl.
interface run_ctrl_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          req;
  logic [1:0]    prog_sel;
  logic          halt_in;
  logic          core_rst;
  logic          load_pc;
  logic [D-1:0]  start_addr;
  logic          run;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic [1:0]    prog_id;

  modport master (
    output req, prog_sel, halt_in,
    input  core_rst, load_pc, start_addr, run, done, timeout, cycles, prog_id
  );

  modport slave (
    input  req, prog_sel, halt_in,
    output core_rst, load_pc, start_addr, run, done, timeout, cycles, prog_id
  );
endinterface

// File: rtl/run_ctrl.sv
// Program-run sequencer: holds the core in reset while idle, jumps the PC to the
// selected program, times the run and ends it on halt (plus drain) or watchdog.
//
// state  | meaning
// IDLE   | core held in reset, waiting for a req rising edge
// LOAD   | one-cycle PC jump to the program start address
// RUN    | core executing, cycle counter and watchdog active
// DRN    | post-halt drain for final writeback
// DONE   | run finished, waits for req to drop
module run_ctrl #(
  parameter int D        = 12,
  parameter int NPROG    = 3,
  parameter int P0_START = 0,
  parameter int P1_START = 100,
  parameter int P2_START = 200,
  parameter int CW       = 16,
  parameter int TMO      = 4000,
  parameter int DRAIN    = 2
) (
  input logic clk,
  input logic reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRN, DONE} state_t;

  localparam int            DW       = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_LD = DW'((DRAIN > 0) ? DRAIN - 1 : 0);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0] CYC_MAX  = '1;

  state_t        state;
  logic          req_q;
  logic [DW-1:0] drain_cnt;
  logic          core_rst_r;
  logic          load_pc_r;
  logic [D-1:0]  start_addr_r;
  logic          run_r;
  logic          done_r;
  logic          timeout_r;
  logic [CW-1:0] cycles_r;
  logic [1:0]    prog_id_r;
  logic          start;

  function automatic logic [D-1:0] prog_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    prog_addr = D'(P0_START);
      2'd1:    prog_addr = D'(P1_START);
      2'd2:    prog_addr = D'(P2_START);
      default: prog_addr = '0;
    endcase
  endfunction

  assign start = bus.req && !req_q && (int'(bus.prog_sel) < NPROG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      drain_cnt    <= '0;
      core_rst_r   <= 1'b1;
      load_pc_r    <= 1'b0;
      start_addr_r <= '0;
      run_r        <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      cycles_r     <= '0;
      prog_id_r    <= '0;
    end else begin
      req_q     <= bus.req;
      load_pc_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            prog_id_r    <= bus.prog_sel;
            start_addr_r <= prog_addr(bus.prog_sel);
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
            cycles_r     <= '0;
            core_rst_r   <= 1'b0;
            load_pc_r    <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
          run_r <= 1'b1;
        end
        RUN: begin
          if (cycles_r != CYC_MAX) cycles_r <= cycles_r + 1'b1;
          // halt has priority over a watchdog expiring on the same cycle
          if (bus.halt_in) begin
            if (DRAIN == 0) begin
              state      <= DONE;
              done_r     <= 1'b1;
              run_r      <= 1'b0;
              core_rst_r <= 1'b1;
            end else begin
              state     <= DRN;
              drain_cnt <= DRAIN_LD;
            end
          end else if (cycles_r == TMO_LAST) begin
            state      <= DONE;
            done_r     <= 1'b1;
            timeout_r  <= 1'b1;
            run_r      <= 1'b0;
            core_rst_r <= 1'b1;
          end
        end
        DRN: begin
          if (drain_cnt == '0) begin
            state      <= DONE;
            done_r     <= 1'b1;
            run_r      <= 1'b0;
            core_rst_r <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          if (!bus.req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_rst   = core_rst_r;
  assign bus.load_pc    = load_pc_r;
  assign bus.start_addr = start_addr_r;
  assign bus.run        = run_r;
  assign bus.done       = done_r;
  assign bus.timeout    = timeout_r;
  assign bus.cycles     = cycles_r;
  assign bus.prog_id    = prog_id_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized runs
// compared against a run-outcome model (cycles, timeout, run length).
module tb_run_ctrl;
  localparam int D     = 12;
  localparam int CW    = 16;
  localparam int TMO   = 50;
  localparam int DRAIN = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  run_ctrl_if #(.D(D), .CW(CW)) bus();

  run_ctrl #(.D(D), .CW(CW), .TMO(TMO), .DRAIN(DRAIN)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int o_nload, o_addr, o_pid_load, o_done_load, o_first_load, o_first_run;
  int o_nrun, o_cyc, o_to, o_crst, o_pid;
  bit o_bound;

  function automatic int exp_addr(input int sel);
    int tbl [3] = '{0, 100, 200};
    return tbl[sel];
  endfunction

  // Outcome of a run whose core halts on RUN cycle h (h=0: never halts).
  function automatic void model(input int h, output int cyc, output int to, output int nrun);
    if (h >= 1 && h <= TMO) begin
      cyc = h; to = 0; nrun = h + DRAIN;
    end else begin
      cyc = TMO; to = 1; nrun = TMO;
    end
  endfunction

  task automatic exec_run(input int sel, input int h, input bit toggle);
    int rc = 0;
    @(posedge clk); #1 bus.req = 1'b0; bus.halt_in = 1'b0;
    @(posedge clk); #1 bus.req = 1'b1; bus.prog_sel = 2'(sel);
    @(posedge clk);
    o_nload = 0; o_first_load = -1; o_first_run = -1; o_nrun = 0; o_bound = 1'b1;
    o_addr = -1; o_pid_load = -1; o_done_load = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      bus.halt_in = 1'b0;
      if (bus.load_pc) begin
        o_nload++;
        if (o_first_load < 0) begin
          o_first_load = i; o_addr = int'(bus.start_addr);
          o_pid_load = int'(bus.prog_id); o_done_load = int'(bus.done);
        end
      end
      if (bus.run) begin
        o_nrun++; rc++;
        if (o_first_run < 0) o_first_run = i;
        if (rc == h) bus.halt_in = 1'b1;
        if (toggle && rc >= 5 && rc <= 8) bus.req = (rc % 2 == 0);
      end
      if (bus.done && o_first_load > 0) begin
        o_bound = 1'b0;
        o_cyc = int'(bus.cycles); o_to = int'(bus.timeout);
        o_crst = int'(bus.core_rst); o_pid = int'(bus.prog_id);
        break;
      end
    end
    bus.halt_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.prog_sel = 2'd0; bus.halt_in = 1'b0;
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %0b expected 1", bus.core_rst); end
    checks++; if ({bus.load_pc, bus.run, bus.done, bus.timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.load_pc, bus.run, bus.done, bus.timeout}); end
    checks++; if (bus.cycles !== '0 || bus.start_addr !== '0 || bus.prog_id !== 2'd0) begin errors++; $display("FAIL reset_values: got cycles=%0d addr=%0d pid=%0d expected 0", bus.cycles, bus.start_addr, bus.prog_id); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_halt_run();
    int ec, et, en;
    model(10, ec, et, en);
    exec_run(1, 10, 1'b0);
    checks++; if (o_bound) begin errors++; $display("FAIL halt_bound: run did not finish within budget"); end
    checks++; if (o_first_load !== 1 || o_nload !== 1) begin errors++; $display("FAIL halt_load: got first=%0d count=%0d expected 1/1", o_first_load, o_nload); end
    checks++; if (o_addr !== 100 || o_pid_load !== 1) begin errors++; $display("FAIL halt_addr: got addr=%0d pid=%0d expected 100/1", o_addr, o_pid_load); end
    checks++; if (o_first_run !== 2) begin errors++; $display("FAIL halt_run_latency: got %0d expected 2", o_first_run); end
    checks++; if (o_nrun !== en) begin errors++; $display("FAIL halt_run_len: got %0d expected %0d", o_nrun, en); end
    checks++; if (o_cyc !== ec || o_to !== et || o_crst !== 1) begin errors++; $display("FAIL halt_end: got cyc=%0d to=%0d crst=%0d expected %0d/%0d/1", o_cyc, o_to, o_crst, ec, et); end
  endtask

  task automatic test_done_hold();
    bit bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.load_pc || bus.run || !bus.done || !bus.core_rst) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL done_hold: got restart or cleared done expected steady DONE"); end
    @(posedge clk); #1 bus.req = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.run !== 1'b0) begin errors++; $display("FAIL done_sticky: got done=%0b run=%0b expected 1/0", bus.done, bus.run); end
    exec_run(0, 5, 1'b0);
    checks++; if (o_done_load !== 0) begin errors++; $display("FAIL done_clear_on_load: got %0d expected 0", o_done_load); end
    checks++; if (o_cyc !== 5 || o_addr !== 0) begin errors++; $display("FAIL restart_run: got cyc=%0d addr=%0d expected 5/0", o_cyc, o_addr); end
  endtask

  task automatic test_timeout();
    int ec, et, en;
    model(0, ec, et, en);
    exec_run(2, 0, 1'b0);
    checks++; if (o_bound) begin errors++; $display("FAIL tmo_bound: run did not finish within budget"); end
    checks++; if (o_nrun !== en) begin errors++; $display("FAIL tmo_run_len: got %0d expected %0d", o_nrun, en); end
    checks++; if (o_cyc !== ec || o_to !== et) begin errors++; $display("FAIL tmo_end: got cyc=%0d to=%0d expected %0d/%0d", o_cyc, o_to, ec, et); end
    checks++; if (o_addr !== 200 || o_pid !== 2) begin errors++; $display("FAIL tmo_prog: got addr=%0d pid=%0d expected 200/2", o_addr, o_pid); end
  endtask

  task automatic test_halt_vs_timeout();
    int ec, et, en;
    model(TMO, ec, et, en);
    exec_run(0, TMO, 1'b0);
    checks++; if (o_nrun !== en) begin errors++; $display("FAIL race_run_len: got %0d expected %0d", o_nrun, en); end
    checks++; if (o_cyc !== ec || o_to !== et) begin errors++; $display("FAIL race_end: got cyc=%0d to=%0d expected %0d/%0d", o_cyc, o_to, ec, et); end
    model(1, ec, et, en);
    exec_run(1, 1, 1'b0);
    checks++; if (o_cyc !== ec || o_nrun !== en) begin errors++; $display("FAIL first_cycle_halt: got cyc=%0d nrun=%0d expected %0d/%0d", o_cyc, o_nrun, ec, en); end
  endtask

  task automatic test_invalid_sel();
    bit bad = 1'b0;
    @(posedge clk); #1 bus.req = 1'b0;
    @(posedge clk); #1 bus.req = 1'b1; bus.prog_sel = 2'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.load_pc || bus.run || !bus.core_rst) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL invalid_sel: got a start expected IDLE"); end
    @(posedge clk); #1 bus.req = 1'b0;
  endtask

  task automatic test_req_toggle();
    int ec, et, en;
    model(30, ec, et, en);
    exec_run(1, 30, 1'b1);
    checks++; if (o_nload !== 1 || o_nrun !== en) begin errors++; $display("FAIL toggle_run: got nload=%0d nrun=%0d expected 1/%0d", o_nload, o_nrun, en); end
    checks++; if (o_cyc !== ec || o_pid !== 1) begin errors++; $display("FAIL toggle_end: got cyc=%0d pid=%0d expected %0d/1", o_cyc, o_pid, ec); end
  endtask

  task automatic test_random();
    int sel, h, ec, et, en;
    for (int n = 0; n < 10; n++) begin
      sel = int'($urandom_range(0, 2));
      h = int'($urandom_range(0, 60));
      model(h, ec, et, en);
      exec_run(sel, h, 1'b0);
      checks++;
      if (o_bound || o_addr !== exp_addr(sel) || o_pid !== sel || o_nrun !== en || o_cyc !== ec || o_to !== et) begin
        errors++;
        $display("FAIL random_run sel=%0d h=%0d: got addr=%0d pid=%0d nrun=%0d cyc=%0d to=%0d expected %0d/%0d/%0d/%0d/%0d",
                 sel, h, o_addr, o_pid, o_nrun, o_cyc, o_to, exp_addr(sel), sel, en, ec, et);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int rc = 0;
    bit bad = 1'b0;
    @(posedge clk); #1 bus.req = 1'b0;
    @(posedge clk); #1 bus.req = 1'b1; bus.prog_sel = 2'd0;
    for (int i = 0; i < 100 && rc < 38; i++) begin
      @(negedge clk);
      if (bus.run) rc++;
    end
    checks++; if (rc !== 38 || bus.cycles !== 16'd37) begin errors++; $display("FAIL midrun_count: got rc=%0d cycles=%0d expected 38/37", rc, bus.cycles); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.core_rst !== 1'b1 || bus.run !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: got crst=%0b run=%0b done=%0b expected 1/0/0", bus.core_rst, bus.run, bus.done); end
    checks++; if (bus.cycles !== '0 || bus.load_pc !== 1'b0 || bus.prog_id !== 2'd0) begin errors++; $display("FAIL midrun_reset_vals: got cycles=%0d load=%0b pid=%0d expected 0", bus.cycles, bus.load_pc, bus.prog_id); end
    bus.req = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.run || bus.load_pc || !bus.core_rst) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL midrun_idle_after: got activity expected IDLE"); end
  endtask

  initial begin
    test_reset();
    test_halt_run();
    test_done_hold();
    test_timeout();
    test_halt_vs_timeout();
    test_invalid_sel();
    test_req_toggle();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
